// File: rtl/mcu_irq_arb_pkg.sv
// Shared constants and types for the MCU interrupt arbiter: sys-target
// command codes, the grant response flag and the FSM state encoding.
package mcu_irq_pkg;

    localparam int PTR_W = 3;

    localparam logic [7:0] CMD_IRQ_POLL   = 8'h01;
    localparam logic [7:0] CMD_MASK_WR    = 8'h02;
    localparam logic [7:0] CMD_IRQ_STATUS = 8'h03;

    localparam logic [7:0] GRANT_VALID = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_MASKWR,
        ST_STATUS,
        ST_IGNORE
    } arb_state_e;

    // Response byte for a successful grant: valid flag plus the source id.
    function automatic logic [7:0] grantByte(input logic [PTR_W-1:0] id);
        return GRANT_VALID | {5'b00000, id};
    endfunction

endpackage

// File: rtl/mcu_irq_arb_if.sv
// Bundle of the sys-target byte channel and the per-source event/ack wires.
// The master side is the MCU/SPI plus the components; the arbiter is the slave.
interface mcu_irq_arb_if #(
    parameter int NUM_SRC = 4
);
    logic               mcu_strobe;
    logic               mcu_start;
    logic [7:0]         mcu_din;
    logic [7:0]         mcu_dout;
    logic [NUM_SRC-1:0] irq_req;
    logic [NUM_SRC-1:0] irq_ack;
    logic               mcu_int;

    modport master (
        output mcu_strobe,
        output mcu_start,
        output mcu_din,
        output irq_req,
        input  mcu_dout,
        input  irq_ack,
        input  mcu_int
    );

    modport slave (
        input  mcu_strobe,
        input  mcu_start,
        input  mcu_din,
        input  irq_req,
        output mcu_dout,
        output irq_ack,
        output mcu_int
    );
endinterface

// File: rtl/mcu_irq_arb_rr_pick.sv
// Combinational round-robin finder: first set request after the last
// granted id, wrapping modulo NUM_SRC.
module rr_pick
    import mcu_irq_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic               hit_o,
    output logic [PTR_W-1:0]   id_o
);

    logic [2*NUM_SRC-1:0] doubled;
    logic [NUM_SRC-1:0]   rotated;
    int                   start;
    int                   idx;

    // Rotate so bit 0 is the slot right after ptr; scanning downwards lets the
    // lowest set bit (closest to the pointer) win.
    always_comb begin
        hit_o   = 1'b0;
        idx     = 0;
        start   = (int'(ptr_i) + 1) % NUM_SRC;
        doubled = {req_i, req_i};
        rotated = NUM_SRC'(doubled >> start);
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                hit_o = 1'b1;
                idx   = (start + j) % NUM_SRC;
            end
        end
        id_o = PTR_W'(idx);
    end

endmodule

// File: rtl/mcu_irq_arb.sv
// Interrupt arbiter: latches component events as pending, raises one level
// interrupt and hands events to the MCU round-robin over the sys byte channel.
module mcu_irq_arb
    import mcu_irq_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input logic          clk,
    input logic          reset,
    mcu_irq_arb_if.slave bus
);

    arb_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]         dout_q, dout_d;
    logic [NUM_SRC-1:0] ack_q, ack_d;
    logic               int_q, int_d;

    logic               grant;
    logic               hit;
    logic [PTR_W-1:0]   hitId;
    logic [NUM_SRC-1:0] clr;

    rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req_i (pending_q & mask_q),
        .ptr_i (rr_ptr_q),
        .hit_o (hit),
        .id_o  (hitId)
    );

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        rr_ptr_d = rr_ptr_q;
        dout_d   = dout_q;
        ack_d    = '0;
        clr      = '0;
        grant    = 1'b0;

        if (bus.mcu_strobe && bus.mcu_start) begin
            case (bus.mcu_din)
                CMD_IRQ_POLL: begin
                    state_d = ST_POLL;
                    grant   = 1'b1;
                end
                CMD_MASK_WR: state_d = ST_MASKWR;
                CMD_IRQ_STATUS: begin
                    state_d = ST_STATUS;
                    dout_d  = {4'(mask_q), 4'(pending_q)};
                end
                default: begin
                    state_d = ST_IGNORE;
                    dout_d  = 8'h00;
                end
            endcase
        end else if (bus.mcu_strobe) begin
            case (state_q)
                ST_POLL: grant = 1'b1;
                ST_MASKWR: begin
                    mask_d  = bus.mcu_din[NUM_SRC-1:0];
                    state_d = ST_IGNORE;
                end
                default: ;
            endcase
        end

        if (grant) begin
            if (hit) begin
                dout_d   = grantByte(hitId);
                clr      = NUM_SRC'(1) << hitId;
                ack_d    = clr;
                rr_ptr_d = hitId;
            end else begin
                dout_d = 8'h00;
            end
        end

        // New events are ORed in after the grant clear so a coincident request survives.
        pending_d = (pending_q & ~clr) | bus.irq_req;
        int_d     = |(pending_q & mask_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            mask_q    <= '1;
            rr_ptr_q  <= PTR_W'(NUM_SRC - 1);
            dout_q    <= 8'h00;
            ack_q     <= '0;
            int_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            rr_ptr_q  <= rr_ptr_d;
            dout_q    <= dout_d;
            ack_q     <= ack_d;
            int_q     <= int_d;
        end
    end

    assign bus.mcu_dout = dout_q;
    assign bus.irq_ack  = ack_q;
    assign bus.mcu_int  = int_q;

endmodule

// File: tb/tb_mcu_irq_arb.sv
// Directed bench for mcu_irq_arb: hand-computed poll, mask, status,
// collision and reset-in-transfer scenarios with NUM_SRC = 4.
module tb_mcu_irq_arb;

    localparam int NUM_SRC = 4;

    logic clk;
    logic reset;
    int   vectorCount;
    int   missCount;

    mcu_irq_arb_if #(.NUM_SRC(NUM_SRC)) bus ();

    mcu_irq_arb #(.NUM_SRC(NUM_SRC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1;
        bus.mcu_strobe = 1'b0;
        bus.mcu_start  = 1'b0;
        bus.mcu_din    = 8'h00;
        bus.irq_req    = '0;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic pulseReq(input logic [NUM_SRC-1:0] vec);
        @(negedge clk);
        bus.irq_req = vec;
        @(negedge clk);
        bus.irq_req = '0;
    endtask

    // Spaced strobe; returns one negedge after the strobe cycle so the
    // registered response and ack pulse are observable.
    task automatic applyStimulus(input logic start, input logic [7:0] data, input logic [NUM_SRC-1:0] reqVec);
        idle(6);
        bus.mcu_strobe = 1'b1;
        bus.mcu_start  = start;
        bus.mcu_din    = data;
        bus.irq_req    = reqVec;
        @(negedge clk);
        bus.mcu_strobe = 1'b0;
        bus.mcu_start  = 1'b0;
        bus.mcu_din    = 8'h00;
        bus.irq_req    = '0;
    endtask

    task automatic checkGrant(input string tag, input logic [7:0] dout, input logic [NUM_SRC-1:0] ack);
        checkOutput({tag, "_dout"}, 32'(bus.mcu_dout), 32'(dout));
        checkOutput({tag, "_ack"},  32'(bus.irq_ack),  32'(ack));
    endtask

    initial begin
        vectorCount    = 0;
        missCount      = 0;
        reset          = 1'b1;
        bus.mcu_strobe = 1'b0;
        bus.mcu_start  = 1'b0;
        bus.mcu_din    = 8'h00;
        bus.irq_req    = '0;

        applyReset();
        idle(1);
        checkOutput("rst_dout", 32'(bus.mcu_dout), 32'h00);
        checkOutput("rst_ack",  32'(bus.irq_ack),  32'h0);
        checkOutput("rst_int",  32'(bus.mcu_int),  32'h0);
        applyStimulus(1'b1, 8'h03, 4'b0000);
        checkGrant("rst_status", 8'hF0, 4'b0000);

        // Single event on source 2.
        pulseReq(4'b0100);
        checkOutput("t1_int_lat1", 32'(bus.mcu_int), 32'h0);
        idle(1);
        checkOutput("t1_int_lat2", 32'(bus.mcu_int), 32'h1);
        applyStimulus(1'b1, 8'h01, 4'b0000);
        checkGrant("t1_poll", 8'h82, 4'b0100);
        idle(1);
        checkOutput("t1_ack_once", 32'(bus.irq_ack), 32'h0);
        idle(1);
        checkOutput("t1_int_clr", 32'(bus.mcu_int), 32'h0);
        applyStimulus(1'b1, 8'h03, 4'b0000);
        checkGrant("t1_status", 8'hF0, 4'b0000);

        // Drain three events in one transfer.
        applyReset();
        pulseReq(4'b1011);
        idle(1);
        checkOutput("t2_int", 32'(bus.mcu_int), 32'h1);
        applyStimulus(1'b1, 8'h01, 4'b0000);
        checkGrant("t2_b0", 8'h80, 4'b0001);
        applyStimulus(1'b0, 8'h00, 4'b0000);
        checkGrant("t2_b1", 8'h81, 4'b0010);
        applyStimulus(1'b0, 8'h00, 4'b0000);
        checkGrant("t2_b2", 8'h83, 4'b1000);
        applyStimulus(1'b0, 8'h00, 4'b0000);
        checkGrant("t2_b3", 8'h00, 4'b0000);

        // Fairness: last grant was 3, so 0 wins over 3.
        pulseReq(4'b1001);
        applyStimulus(1'b1, 8'h01, 4'b0000);
        checkGrant("t3_b0", 8'h80, 4'b0001);
        applyStimulus(1'b0, 8'h00, 4'b0000);
        checkGrant("t3_b1", 8'h83, 4'b1000);
        applyStimulus(1'b0, 8'h00, 4'b0000);
        checkGrant("t3_b2", 8'h00, 4'b0000);

        // Masking hides source 2 until re-enabled.
        applyStimulus(1'b1, 8'h02, 4'b0000);
        applyStimulus(1'b0, 8'h0B, 4'b0000);
        pulseReq(4'b0100);
        idle(2);
        checkOutput("t4_int_masked", 32'(bus.mcu_int), 32'h0);
        applyStimulus(1'b1, 8'h03, 4'b0000);
        checkGrant("t4_status", 8'hB4, 4'b0000);
        applyStimulus(1'b1, 8'h02, 4'b0000);
        applyStimulus(1'b0, 8'h0F, 4'b0000);
        checkOutput("t4_int_lag", 32'(bus.mcu_int), 32'h0);
        idle(1);
        checkOutput("t4_int_unmask", 32'(bus.mcu_int), 32'h1);
        applyStimulus(1'b1, 8'h01, 4'b0000);
        checkGrant("t4_poll", 8'h82, 4'b0100);
        idle(2);
        checkOutput("t4_int_clr", 32'(bus.mcu_int), 32'h0);

        // New request on the same cycle as the grant of that source.
        pulseReq(4'b0010);
        applyStimulus(1'b1, 8'h01, 4'b0010);
        checkGrant("t5_poll", 8'h81, 4'b0010);
        idle(2);
        checkOutput("t5_int_kept", 32'(bus.mcu_int), 32'h1);
        applyStimulus(1'b0, 8'h00, 4'b0000);
        checkGrant("t5_regrant", 8'h81, 4'b0010);
        applyStimulus(1'b0, 8'h00, 4'b0000);
        checkGrant("t5_empty", 8'h00, 4'b0000);
        idle(2);
        checkOutput("t5_int_clr", 32'(bus.mcu_int), 32'h0);

        // Reset inside a poll transfer, then stray bytes and an unknown command.
        applyStimulus(1'b1, 8'h01, 4'b0000);
        checkGrant("t6_poll_empty", 8'h00, 4'b0000);
        applyReset();
        pulseReq(4'b0001);
        idle(2);
        checkOutput("t6_int", 32'(bus.mcu_int), 32'h1);
        applyStimulus(1'b0, 8'h01, 4'b0000);
        checkGrant("t6_stray", 8'h00, 4'b0000);
        applyStimulus(1'b1, 8'h03, 4'b0000);
        checkGrant("t6_status", 8'hF1, 4'b0000);
        applyStimulus(1'b0, 8'h55, 4'b0000);
        checkGrant("t6_status_hold", 8'hF1, 4'b0000);
        applyStimulus(1'b1, 8'h7E, 4'b0000);
        checkGrant("t6_unknown", 8'h00, 4'b0000);
        applyStimulus(1'b0, 8'h01, 4'b0000);
        checkGrant("t6_ignore", 8'h00, 4'b0000);
        idle(1);
        checkOutput("t6_int_held", 32'(bus.mcu_int), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
